// File: rtl/sram17x8_ctrl_pkg.sv
// Shared types and constants for the 17x8 asynchronous SRAM initiator.
package sram17x8_ctrl_pkg;

  // SRAM geometry
  localparam int unsigned SRAM_ADDR_W = 17;
  localparam int unsigned SRAM_DATA_W = 8;

  // Down-counter width and the largest programmable cycle count it supports
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = 15;

  // Default strobe timing, shared with the board-level bootstrap loader
  localparam int unsigned DEF_RD_WAIT  = 1;
  localparam int unsigned DEF_WR_SETUP = 1;
  localparam int unsigned DEF_WR_PULSE = 1;
  localparam int unsigned DEF_WR_HOLD  = 1;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } sram_state_e;

  // Single-beat request payload as seen on the datapath side
  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

  // Counter reload value for a phase lasting 'cycles' clocks (cycles >= 1)
  function automatic logic [CNT_W-1:0] phase_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sram17x8_ctrl.sv
// Synchronous initiator for a 17-bit address, 8-bit data asynchronous SRAM.
// Turns single-beat valid/ready requests into N_OE / N_WE strobe sequences and
// reports completion on a one-cycle response strobe. All SRAM-side outputs are
// registered so the strobes never glitch.
module sram17x8_ctrl
  import sram17x8_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = SRAM_ADDR_W,
  parameter int unsigned DATA_W   = SRAM_DATA_W,
  parameter int unsigned RD_WAIT  = DEF_RD_WAIT,
  parameter int unsigned WR_SETUP = DEF_WR_SETUP,
  parameter int unsigned WR_PULSE = DEF_WR_PULSE,
  parameter int unsigned WR_HOLD  = DEF_WR_HOLD
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_n_we,
  output logic              sram_n_oe,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  // Reject timing parameters the 4-bit counter cannot represent
  if (RD_WAIT > CNT_MAX) begin : g_bad_rd_wait
    $error("sram17x8_ctrl: RD_WAIT must be in 0..15");
  end
  if (WR_SETUP < 1 || WR_SETUP > CNT_MAX) begin : g_bad_wr_setup
    $error("sram17x8_ctrl: WR_SETUP must be in 1..15");
  end
  if (WR_PULSE < 1 || WR_PULSE > CNT_MAX) begin : g_bad_wr_pulse
    $error("sram17x8_ctrl: WR_PULSE must be in 1..15");
  end
  if (WR_HOLD < 1 || WR_HOLD > CNT_MAX) begin : g_bad_wr_hold
    $error("sram17x8_ctrl: WR_HOLD must be in 1..15");
  end

  // Counter reload values per phase; a phase ends when the counter reads zero
  localparam logic [CNT_W-1:0] RD_LOAD    = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] SETUP_LOAD = phase_load(WR_SETUP);
  localparam logic [CNT_W-1:0] PULSE_LOAD = phase_load(WR_PULSE);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = phase_load(WR_HOLD);

  sram_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero_c;

  assign cnt_zero_c = (cnt == '0);

  // Request sequencing: strobes, bus capture, wait counter and response
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_n_we  <= 1'b1;
      sram_n_oe  <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            sram_addr <= req_addr;
            req_ready <= 1'b0;
            if (req_we) begin
              // N_WE stays high through the setup phase
              sram_wdata <= req_wdata;
              cnt        <= SETUP_LOAD;
              state      <= ST_WR_SETUP;
            end else begin
              sram_n_oe <= 1'b0;
              cnt       <= RD_LOAD;
              state     <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (cnt_zero_c) begin
            rsp_rdata <= sram_rdata;
            rsp_valid <= 1'b1;
            sram_n_oe <= 1'b1;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_WR_SETUP: begin
          if (cnt_zero_c) begin
            sram_n_we <= 1'b0;
            cnt       <= PULSE_LOAD;
            state     <= ST_WR_PULSE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_WR_PULSE: begin
          if (cnt_zero_c) begin
            sram_n_we <= 1'b1;
            cnt       <= HOLD_LOAD;
            state     <= ST_WR_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_WR_HOLD: begin
          if (cnt_zero_c) begin
            rsp_valid <= 1'b1;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          sram_n_we <= 1'b1;
          sram_n_oe <= 1'b1;
          req_ready <= 1'b1;
          cnt       <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram17x8_ctrl.sv
// Testbench for sram17x8_ctrl: two instances (default timing and stretched
// timing), each with a behavioural asynchronous SRAM that latches on N_WE fall.
module tb_sram17x8_ctrl;
  import sram17x8_ctrl_pkg::*;

  localparam int unsigned AW = SRAM_ADDR_W;
  localparam int unsigned DW = SRAM_DATA_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_rst;
  logic          va, vb;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          a_ready, a_rsp, a_n_we, a_n_oe;
  logic [DW-1:0] a_rdata, a_wdata, a_sram_rdata;
  logic [AW-1:0] a_addr;
  logic          b_ready, b_rsp, b_n_we, b_n_oe;
  logic [DW-1:0] b_rdata, b_wdata, b_sram_rdata;
  logic [AW-1:0] b_addr;

  sram17x8_ctrl u_dut_a (
    .clk(clk), .n_rst(n_rst), .req_valid(va), .req_ready(a_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp), .rsp_rdata(a_rdata), .sram_addr(a_addr),
    .sram_n_we(a_n_we), .sram_n_oe(a_n_oe), .sram_wdata(a_wdata),
    .sram_rdata(a_sram_rdata)
  );

  sram17x8_ctrl #(.RD_WAIT(3), .WR_SETUP(2), .WR_PULSE(3), .WR_HOLD(2)) u_dut_b (
    .clk(clk), .n_rst(n_rst), .req_valid(vb), .req_ready(b_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp), .rsp_rdata(b_rdata), .sram_addr(b_addr),
    .sram_n_we(b_n_we), .sram_n_oe(b_n_oe), .sram_wdata(b_wdata),
    .sram_rdata(b_sram_rdata)
  );

  // Behavioural SRAMs: latch on N_WE fall; drive inverted data when N_OE is high
  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:(1<<AW)-1];
  always @(negedge a_n_we) mem_a[a_addr] <= a_wdata;
  always @(negedge b_n_we) mem_b[b_addr] <= b_wdata;
  assign a_sram_rdata = !a_n_oe ? mem_a[a_addr] : ~mem_a[a_addr];
  assign b_sram_rdata = !b_n_oe ? mem_b[b_addr] : ~mem_b[b_addr];

  // Reference contents per instance, keyed by address (absent = 0)
  logic [DW-1:0] ref_a [int];
  logic [DW-1:0] ref_b [int];

  function automatic logic [DW-1:0] ref_rd(input bit sel, input logic [AW-1:0] a);
    if (sel) return ref_b.exists(int'(a)) ? ref_b[int'(a)] : '0;
    return ref_a.exists(int'(a)) ? ref_a[int'(a)] : '0;
  endfunction

  // View of whichever instance the current transaction targets
  bit            cur_sel = 1'b0;
  logic          m_ready, m_rsp, m_n_we, m_n_oe;
  logic [DW-1:0] m_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  assign m_ready = cur_sel ? b_ready : a_ready;
  assign m_rsp   = cur_sel ? b_rsp   : a_rsp;
  assign m_n_we  = cur_sel ? b_n_we  : a_n_we;
  assign m_n_oe  = cur_sel ? b_n_oe  : a_n_oe;
  assign m_rdata = cur_sel ? b_rdata : a_rdata;
  assign m_wdata = cur_sel ? b_wdata : a_wdata;
  assign m_addr  = cur_sel ? b_addr  : a_addr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int            wait_n;
    int            lat;
    logic [DW-1:0] rd;
    int            we_lo;
    int            oe_lo;
    int            setup_hi;
    int            hold_hi;
    bit            to;
    bit            busy_ready;
    bit            bus_moved;
    bit            both_low;
    bit            rsp_ok;
  } res_t;

  task automatic set_valid(input bit sel, input logic v);
    if (sel) vb = v; else va = v;
  endtask

  // Issue one request at a negedge and observe it until its response strobe
  task automatic do_req(input bit sel, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit hold, output res_t r);
    bit seen_low;
    bit done;
    r.wait_n = 0; r.lat = -1; r.rd = '0; r.we_lo = 0; r.oe_lo = 0;
    r.setup_hi = 0; r.hold_hi = 0; r.to = 1'b0; r.busy_ready = 1'b0;
    r.bus_moved = 1'b0; r.both_low = 1'b0; r.rsp_ok = 1'b0;
    seen_low = 1'b0; done = 1'b0;
    cur_sel = sel;
    req_we = we; req_addr = a; req_wdata = d;
    set_valid(sel, 1'b1);
    while (m_ready !== 1'b1 && r.wait_n < 50) begin
      @(negedge clk);
      r.wait_n++;
    end
    if (m_ready !== 1'b1) begin
      r.to = 1'b1;
      set_valid(sel, 1'b0);
      return;
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      r.lat = k;
      if (m_addr !== a || (we && m_wdata !== d)) r.bus_moved = 1'b1;
      if (m_n_we === 1'b0 && m_n_oe === 1'b0) r.both_low = 1'b1;
      if (m_rsp === 1'b1) begin
        r.rd     = m_rdata;
        r.rsp_ok = (m_ready === 1'b1) && (m_n_we === 1'b1) && (m_n_oe === 1'b1);
        done     = 1'b1;
        break;
      end
      if (m_ready !== 1'b0) r.busy_ready = 1'b1;
      if (m_n_we === 1'b0) begin
        r.we_lo++;
        seen_low = 1'b1;
      end else if (we) begin
        if (seen_low) r.hold_hi++; else r.setup_hi++;
      end
      if (m_n_oe === 1'b0) r.oe_lo++;
      // Request inputs must be ignored while busy
      req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom);
      if (!hold) set_valid(sel, 1'($urandom));
    end
    if (!done) r.to = 1'b1;
    set_valid(sel, hold);
    if (done && we) begin
      if (sel) ref_b[int'(a)] = d; else ref_a[int'(a)] = d;
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; va = 1'b1; vb = 1'b1;
    req_we = 1'b1; req_addr = 17'h1ABCD; req_wdata = 8'hC3;
    repeat (3) @(negedge clk);
    for (int i = 0; i < (1 << AW); i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    total++; if (a_n_we !== 1'b1) begin bad++; $display("FAIL reset_n_we: got %b want 1", a_n_we); end
    total++; if (a_n_oe !== 1'b1) begin bad++; $display("FAIL reset_n_oe: got %b want 1", a_n_oe); end
    total++; if (a_rsp !== 1'b0) begin bad++; $display("FAIL reset_rsp: got %b want 0", a_rsp); end
    total++; if (a_addr !== 17'h00000) begin bad++; $display("FAIL reset_addr: got %h want 00000", a_addr); end
    total++; if (a_wdata !== 8'h00 || a_rdata !== 8'h00) begin
      bad++; $display("FAIL reset_data: got wdata=%h rdata=%h want 00/00", a_wdata, a_rdata); end
    total++; if (b_n_we !== 1'b1 || b_n_oe !== 1'b1) begin
      bad++; $display("FAIL reset_b_strobes: got we=%b oe=%b want 1/1", b_n_we, b_n_oe); end
    n_rst = 1'b1;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", a_ready); end
    va = 1'b0; vb = 1'b0;
    @(negedge clk);
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      bad++; $display("FAIL reset_idle_after: got a=%b b=%b want 1/1", a_ready, b_ready); end
  endtask

  task automatic test_basic();
    res_t r;
    do_req(1'b0, 1'b1, 17'h1ABCD, 8'h5A, 1'b0, r);
    total++; if (r.to) begin bad++; $display("FAIL basic_wr_timeout: got timeout want response"); end
    total++; if (r.lat !== 3) begin bad++; $display("FAIL basic_wr_lat: got %0d want 3", r.lat); end
    total++; if (r.we_lo !== 1 || r.oe_lo !== 0) begin
      bad++; $display("FAIL basic_wr_strobes: got we_lo=%0d oe_lo=%0d want 1/0", r.we_lo, r.oe_lo); end
    total++; if (r.bus_moved || r.both_low || r.busy_ready || !r.rsp_ok) begin
      bad++; $display("FAIL basic_wr_bus: got moved=%b both=%b busyrdy=%b rspok=%b want 0/0/0/1",
                      r.bus_moved, r.both_low, r.busy_ready, r.rsp_ok); end
    @(negedge clk);
    total++; if (a_rsp !== 1'b0) begin bad++; $display("FAIL basic_rsp_width: got %b want 0", a_rsp); end
    do_req(1'b0, 1'b0, 17'h1ABCD, 8'h00, 1'b0, r);
    total++; if (r.lat !== 2) begin bad++; $display("FAIL basic_rd_lat: got %0d want 2", r.lat); end
    total++; if (r.oe_lo !== 2 || r.we_lo !== 0) begin
      bad++; $display("FAIL basic_rd_strobes: got oe_lo=%0d we_lo=%0d want 2/0", r.oe_lo, r.we_lo); end
    total++; if (r.rd !== 8'h5A) begin bad++; $display("FAIL basic_rd_data: got %h want 5a", r.rd); end
  endtask

  task automatic test_back_to_back();
    res_t r;
    logic [AW-1:0] ad [4];
    logic          we [4];
    logic [DW-1:0] dd [4];
    logic [DW-1:0] exp_rd [4];
    ad[0] = 17'h00000; we[0] = 1'b1; dd[0] = 8'h11;
    ad[1] = 17'h00000; we[1] = 1'b0; dd[1] = 8'h00; exp_rd[1] = 8'h11;
    ad[2] = 17'h1FFFF; we[2] = 1'b1; dd[2] = 8'hEE;
    ad[3] = 17'h1FFFF; we[3] = 1'b0; dd[3] = 8'h00; exp_rd[3] = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, we[i], ad[i], dd[i], 1'b1, r);
      total++; if (r.to || r.lat !== (we[i] ? 3 : 2)) begin
        bad++; $display("FAIL b2b_lat[%0d]: got %0d to=%b want %0d", i, r.lat, r.to, we[i] ? 3 : 2); end
      total++; if (i > 0 && r.wait_n !== 0) begin
        bad++; $display("FAIL b2b_dead_cycle[%0d]: got wait=%0d want 0", i, r.wait_n); end
      total++; if (r.busy_ready || !r.rsp_ok || r.bus_moved) begin
        bad++; $display("FAIL b2b_ready[%0d]: got busyrdy=%b rspok=%b moved=%b want 0/1/0",
                        i, r.busy_ready, r.rsp_ok, r.bus_moved); end
      if (!we[i]) begin
        total++; if (r.rd !== exp_rd[i]) begin
          bad++; $display("FAIL b2b_rd[%0d]: got %h want %h", i, r.rd, exp_rd[i]); end
      end
    end
    va = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timing();
    res_t r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = AW'($urandom); d = DW'($urandom);
    do_req(1'b1, 1'b1, a, d, 1'b0, r);
    total++; if (r.to || r.lat !== 7) begin bad++; $display("FAIL timing_wr_lat: got %0d want 7", r.lat); end
    total++; if (r.setup_hi !== 2 || r.we_lo !== 3 || r.hold_hi !== 2) begin
      bad++; $display("FAIL timing_wr_shape: got setup=%0d low=%0d hold=%0d want 2/3/2",
                      r.setup_hi, r.we_lo, r.hold_hi); end
    total++; if (r.oe_lo !== 0 || r.bus_moved) begin
      bad++; $display("FAIL timing_wr_bus: got oe_lo=%0d moved=%b want 0/0", r.oe_lo, r.bus_moved); end
    do_req(1'b1, 1'b0, a, 8'h00, 1'b0, r);
    total++; if (r.to || r.lat !== 4) begin bad++; $display("FAIL timing_rd_lat: got %0d want 4", r.lat); end
    total++; if (r.oe_lo !== 4 || r.we_lo !== 0) begin
      bad++; $display("FAIL timing_rd_oe: got oe_lo=%0d we_lo=%0d want 4/0", r.oe_lo, r.we_lo); end
    total++; if (r.rd !== d) begin bad++; $display("FAIL timing_rd_data: got %h want %h", r.rd, d); end
  endtask

  task automatic test_abort();
    res_t r;
    bit   rsp_seen;
    // Abort during WR_PULSE: the SRAM has already latched the data
    cur_sel = 1'b0;
    req_we = 1'b1; req_addr = 17'h00010; req_wdata = 8'hA5; va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    total++; if (a_n_we !== 1'b1) begin bad++; $display("FAIL abort_setup_we: got %b want 1", a_n_we); end
    @(negedge clk);
    total++; if (a_n_we !== 1'b0) begin bad++; $display("FAIL abort_pulse_we: got %b want 0", a_n_we); end
    #1 n_rst = 1'b0;
    #1;
    total++; if (a_n_we !== 1'b1 || a_ready !== 1'b1) begin
      bad++; $display("FAIL abort_async: got we=%b ready=%b want 1/1", a_n_we, a_ready); end
    @(negedge clk);
    n_rst = 1'b1;
    rsp_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (a_rsp !== 1'b0) rsp_seen = 1'b1;
    end
    total++; if (rsp_seen) begin bad++; $display("FAIL abort_no_rsp: got rsp=1 want 0"); end
    ref_a[32'h10] = 8'hA5;
    do_req(1'b0, 1'b0, 17'h00010, 8'h00, 1'b0, r);
    total++; if (r.to || r.rd !== 8'hA5) begin
      bad++; $display("FAIL abort_pulse_data: got %h want a5", r.rd); end
    // Abort during WR_SETUP: the location keeps its prior value
    do_req(1'b0, 1'b1, 17'h00020, 8'h77, 1'b0, r);
    req_we = 1'b1; req_addr = 17'h00020; req_wdata = 8'h3C; va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    #1 n_rst = 1'b0;
    #1;
    total++; if (a_n_we !== 1'b1 || a_rsp !== 1'b0) begin
      bad++; $display("FAIL abort_setup_state: got we=%b rsp=%b want 1/0", a_n_we, a_rsp); end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    do_req(1'b0, 1'b0, 17'h00020, 8'h00, 1'b0, r);
    total++; if (r.to || r.rd !== 8'h77) begin
      bad++; $display("FAIL abort_setup_data: got %h want 77", r.rd); end
  endtask

  task automatic test_soak();
    res_t          r;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
    for (int i = 0; i < 10000; i++) begin
      we = 1'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? AW'(17'h1FFFF - AW'($urandom_range(0, 7)))
                                       : AW'($urandom_range(0, 31));
      d  = DW'($urandom);
      exp = ref_rd(1'b0, a);
      do_req(1'b0, we, a, d, 1'($urandom), r);
      total++; if (r.to || r.lat !== (we ? 3 : 2)) begin
        bad++; $display("FAIL soak_lat[%0d]: got %0d to=%b want %0d", i, r.lat, r.to, we ? 3 : 2); end
      total++; if (r.both_low || r.bus_moved || !r.rsp_ok || r.busy_ready) begin
        bad++; $display("FAIL soak_bus[%0d]: got both=%b moved=%b rspok=%b busyrdy=%b want 0/0/1/0",
                        i, r.both_low, r.bus_moved, r.rsp_ok, r.busy_ready); end
      total++; if (we ? (r.we_lo !== 1 || r.oe_lo !== 0) : (r.oe_lo !== 2 || r.we_lo !== 0)) begin
        bad++; $display("FAIL soak_strobes[%0d]: got we_lo=%0d oe_lo=%0d", i, r.we_lo, r.oe_lo); end
      if (!we) begin
        total++; if (r.rd !== exp) begin
          bad++; $display("FAIL soak_rd[%0d]: addr %h got %h want %h", i, a, r.rd, exp); end
      end
    end
    va = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timing();
    test_abort();
    test_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
